// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift pattern sequencer.
package shift_seq_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_SIZE   = 16;
  localparam int DEF_RATE_W = 16;

  // Command opcodes carried on cmd_op
  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_WRITE    = 3'd1,
    OP_RUN      = 3'd2,
    OP_STOP     = 3'd3,
    OP_STEP     = 3'd4,
    OP_SET_RATE = 3'd5,
    OP_SET_DIR  = 3'd6,
    OP_CLEAR    = 3'd7
  } op_e;

  // Opcode 0 doubles as READ when readback is built in
  localparam logic [2:0] OP_READ = 3'd0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Power-on pattern, index 0 first; larger stores are zero-filled
  localparam int RST_PAT_LEN = 16;
  localparam logic [7:0] RST_PATTERN [RST_PAT_LEN] = '{
    8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h20, 8'h40, 8'hFF,
    8'hFF, 8'h40, 8'h20, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] reset_elem(input int idx);
    logic [3:0] sel;
    sel = idx[3:0];
    if (idx < RST_PAT_LEN) return RST_PATTERN[sel];
    return 8'h00;
  endfunction

endpackage

// File: rtl/shift_pattern_sequencer_prescaler.sv
// Rate prescaler: counts 0..rate while enabled and flags the cycle a shift is due.
module shift_rate_prescaler #(
  parameter int RATE_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_i,
  input  logic              clear_i,
  input  logic [RATE_W-1:0] rate_i,
  output logic              shift_due_o
);

  logic [RATE_W-1:0] cnt_q;
  logic [RATE_W-1:0] cnt_d;

  assign shift_due_o = enable_i && (cnt_q == rate_i);

  // Counter restarts after each due cycle and is parked at zero when disabled
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!enable_i || clear_i || shift_due_o) cnt_d = '0;
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/shift_pattern_sequencer.sv
// Rotating pattern store with command interface.
// Optional readback is enabled by defining SHIFT_SEQ_READBACK_EN.
module shift_pattern_sequencer
  import shift_seq_pkg::*;
#(
  parameter int                WIDTH        = DEF_WIDTH,
  parameter int                SIZE         = DEF_SIZE,
  parameter int                RATE_W       = DEF_RATE_W,
  parameter logic [RATE_W-1:0] DEFAULT_RATE = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_op,
  input  logic [$clog2(SIZE)-1:0] cmd_addr,
  input  logic [RATE_W-1:0]       cmd_arg,
  output logic [WIDTH*SIZE-1:0]   reg_out,
  output logic                    running,
  output logic                    shift_pulse,
  output logic                    wrap_pulse,
  output logic                    rd_valid,
  output logic [WIDTH-1:0]        rd_data
);

  localparam int AW = $clog2(SIZE);

  state_e            state_q, state_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic              dir_q, dir_d;
  logic [AW-1:0]     pos_q, pos_d;
  logic [WIDTH-1:0]  elem_q [SIZE];
  logic              shift_pulse_q, wrap_pulse_q;

  logic shift_due, cmd_fire, pre_clear, step_req, wr_en, clr_all, do_shift;
  op_e  op;

  assign op        = op_e'(cmd_op);
  // A due shift holds commands off for one cycle so writes never race a shift
  assign cmd_ready = !shift_due;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign running   = (state_q == ST_RUN);

  shift_rate_prescaler #(.RATE_W(RATE_W)) u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .enable_i   (state_q == ST_RUN),
    .clear_i    (pre_clear),
    .rate_i     (rate_q),
    .shift_due_o(shift_due)
  );

  // Command decode and control next-state
  always_comb begin
    state_d   = state_q;
    rate_d    = rate_q;
    dir_d     = dir_q;
    pre_clear = 1'b0;
    step_req  = 1'b0;
    wr_en     = 1'b0;
    clr_all   = 1'b0;
    if (cmd_fire) begin
      case (op)
        OP_WRITE:    wr_en = 1'b1;
        OP_RUN:      if (state_q == ST_IDLE) begin
                       state_d   = ST_RUN;
                       pre_clear = 1'b1;
                     end
        OP_STOP:     state_d = ST_IDLE;
        OP_STEP:     step_req = (state_q == ST_IDLE);
        OP_SET_RATE: begin
                       rate_d    = cmd_arg;
                       pre_clear = 1'b1;
                     end
        OP_SET_DIR:  dir_d = cmd_arg[0];
        OP_CLEAR:    clr_all = 1'b1;
        default:     ;
      endcase
    end
    do_shift = shift_due || step_req;
  end

  // Rotation position tracks net shifts; CLEAR realigns it to zero
  always_comb begin
    pos_d = pos_q;
    if (clr_all)       pos_d = '0;
    else if (do_shift) pos_d = dir_q ? (pos_q - 1'b1) : (pos_q + 1'b1);
  end

  // Control registers and status strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      rate_q        <= DEFAULT_RATE;
      dir_q         <= 1'b0;
      pos_q         <= '0;
      shift_pulse_q <= 1'b0;
      wrap_pulse_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      rate_q        <= rate_d;
      dir_q         <= dir_d;
      pos_q         <= pos_d;
      shift_pulse_q <= do_shift;
      wrap_pulse_q  <= do_shift && (pos_d == '0);
    end
  end

  assign shift_pulse = shift_pulse_q;
  assign wrap_pulse  = wrap_pulse_q;

  generate
    for (genvar gi = 0; gi < SIZE; gi++) begin : g_elem
      localparam int               PREV    = (gi + SIZE - 1) % SIZE;
      localparam int               NEXT    = (gi + 1) % SIZE;
      localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(reset_elem(gi));

      logic [WIDTH-1:0] elem_d;

      // Element next value: clear beats shift beats write
      always_comb begin
        elem_d = elem_q[gi];
        if (clr_all)       elem_d = '0;
        else if (do_shift) elem_d = dir_q ? elem_q[NEXT] : elem_q[PREV];
        else if (wr_en && (cmd_addr == AW'(gi))) elem_d = cmd_arg[WIDTH-1:0];
      end

      // Element storage
      always_ff @(posedge clk or posedge rst) begin
        if (rst) elem_q[gi] <= RST_VAL;
        else     elem_q[gi] <= elem_d;
      end

      assign reg_out[gi*WIDTH +: WIDTH] = elem_q[gi];
    end
  endgenerate

`ifdef SHIFT_SEQ_READBACK_EN
  logic             rd_valid_q;
  logic [WIDTH-1:0] rd_data_q;

  // Readback captures the element as it stood when the READ was accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= cmd_fire && (cmd_op == OP_READ);
      if (cmd_fire && (cmd_op == OP_READ)) rd_data_q <= elem_q[cmd_addr];
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
`else
  assign rd_valid = 1'b0;
  assign rd_data  = '0;
`endif

endmodule

// File: tb/tb_shift_pattern_sequencer.sv
// Scoreboard bench for shift_pattern_sequencer (default parameters).
module tb_shift_pattern_sequencer;
  import shift_seq_pkg::*;

  localparam logic [127:0] RST_FLAT = 128'h00000000_102040FF_FF402010_00000000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid, cmd_ready;
  logic [2:0]   cmd_op;
  logic [3:0]   cmd_addr;
  logic [15:0]  cmd_arg;
  logic [127:0] reg_out;
  logic         running, shift_pulse, wrap_pulse, rd_valid;
  logic [7:0]   rd_data;

  shift_pattern_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_arg(cmd_arg), .reg_out(reg_out),
    .running(running), .shift_pulse(shift_pulse), .wrap_pulse(wrap_pulse),
    .rd_valid(rd_valid), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] pat;
    logic         wrap;
    int           cyc;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] rd_q[$];
  exp_t       mon_e;
  logic [7:0] mon_rd;

  int n_checks = 0;
  int n_fail   = 0;
  int last_acc = 0;

  // Reference model state
  logic [7:0] m_elem [16];
  int         m_pos;
  logic       m_dir, m_run;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int val);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual=%0d required=none", name, val);
  endtask

  task automatic model_reset();
    logic [127:0] f;
    f = RST_FLAT;
    for (int i = 0; i < 16; i++) m_elem[i] = f[i*8 +: 8];
    m_pos = 0;
    m_dir = 1'b0;
    m_run = 1'b0;
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = m_elem[i];
    return r;
  endfunction

  // Apply one rotation to the model and queue the expected snapshot
  task automatic push_shift(input int exp_cyc);
    logic [7:0] t [16];
    exp_t e;
    for (int i = 0; i < 16; i++) t[i] = m_elem[i];
    for (int i = 0; i < 16; i++) m_elem[i] = m_dir ? t[(i + 1) % 16] : t[(i + 15) % 16];
    m_pos = m_dir ? (m_pos + 15) % 16 : (m_pos + 1) % 16;
    e.pat  = model_flat();
    e.wrap = (m_pos == 0);
    e.cyc  = exp_cyc;
    sb_q.push_back(e);
  endtask

  task automatic apply_model(input logic [2:0] op, input logic [3:0] addr,
                             input logic [15:0] arg, input int acc);
    case (op)
      3'd1: m_elem[addr] = arg[7:0];
      3'd2: m_run = 1'b1;
      3'd3: m_run = 1'b0;
      3'd4: if (!m_run) push_shift(acc);
      3'd6: m_dir = arg[0];
      3'd7: begin
        for (int i = 0; i < 16; i++) m_elem[i] = 8'h00;
        m_pos = 0;
      end
`ifdef SHIFT_SEQ_READBACK_EN
      3'd0: rd_q.push_back(m_elem[addr]);
`endif
      default: ;
    endcase
  endtask

  // Offer a command, wait (bounded) for acceptance, return at the following negedge
  task automatic send(input logic [2:0] op, input logic [3:0] addr, input logic [15:0] arg);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_arg = arg;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      fail_now("send_timeout", int'(op));
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    last_acc = cyc + 1;
    apply_model(op, addr, arg, last_acc);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 3'd0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb_q.size() != 0) begin
      fail_now("drain_timeout", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic wait_cyc(input int t);
    for (int i = 0; i < 1000 && cyc < t; i++) @(negedge clk);
  endtask

  // Monitor: pops an expectation each time the DUT strobes
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (shift_pulse) begin
        if (sb_q.size() == 0) fail_now("unexpected_shift_pulse", cyc);
        else begin
          mon_e = sb_q.pop_front();
          chk("shift_pattern", reg_out, mon_e.pat);
          chk("shift_wrap", {127'd0, wrap_pulse}, {127'd0, mon_e.wrap});
          chk("shift_cycle", cyc, mon_e.cyc);
        end
      end else if (wrap_pulse) fail_now("wrap_without_shift", cyc);
      if (rd_valid) begin
        if (rd_q.size() == 0) fail_now("unexpected_rd_valid", cyc);
        else begin
          mon_rd = rd_q.pop_front();
          chk("rd_data", rd_data, mon_rd);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int a;

  initial begin
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_addr = 4'd0; cmd_arg = 16'd0;
    model_reset();

    // Reset state, then idle
    repeat (3) @(negedge clk);
    chk("rst_pattern", reg_out, RST_FLAT);
    chk("rst_running", running, 1'b0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_pattern", reg_out, RST_FLAT);
    chk("idle_elem7", reg_out[63:56], 8'hFF);
    chk("idle_elem4", reg_out[39:32], 8'h10);
    chk("idle_running", running, 1'b0);
    chk("idle_ready", cmd_ready, 1'b1);
    chk("idle_rd_valid", rd_valid, 1'b0);
    chk("idle_rd_data", rd_data, 8'h00);

    // Rate 3: shift every 4 cycles, full revolution wraps once
    send(OP_SET_RATE, 4'd0, 16'd3);
    send(OP_RUN, 4'd0, 16'd0);
    a = last_acc;
    chk("run_running", running, 1'b1);
    for (int k = 1; k <= 16; k++) push_shift(a + 4*k);
    wait_cyc(a + 4);
    chk("first_shift_elem8", reg_out[71:64], 8'hFF);
    wait_drain(200);
    send(OP_STOP, 4'd0, 16'd0);
    chk("stop_running", running, 1'b0);
    chk("rev_pattern", reg_out, RST_FLAT);

    // Rate 1: five forward, reverse direction, five back to position 0
    send(OP_SET_RATE, 4'd0, 16'd1);
    send(OP_RUN, 4'd0, 16'd0);
    a = last_acc;
    for (int k = 1; k <= 5; k++) push_shift(a + 2*k);
    wait_drain(50);
    send(OP_SET_DIR, 4'd0, 16'd1);
    for (int k = 6; k <= 10; k++) push_shift(a + 2*k);
    wait_drain(50);
    send(OP_STOP, 4'd0, 16'd0);
    chk("dir_back_pattern", reg_out, RST_FLAT);
    send(OP_SET_DIR, 4'd0, 16'd0);

    // Idle writes then a single STEP
    send(OP_WRITE, 4'd3, 16'h00A5);
    chk("write_elem3", reg_out[31:24], 8'hA5);
    send(OP_WRITE, 4'd15, 16'h003C);
    send(OP_STEP, 4'd0, 16'd0);
    chk("step_elem4", reg_out[39:32], 8'hA5);
    chk("step_elem0", reg_out[7:0], 8'h3C);
    repeat (6) @(negedge clk);

    // STEP while running is ignored
    send(OP_SET_RATE, 4'd0, 16'd7);
    send(OP_RUN, 4'd0, 16'd0);
    a = last_acc;
    send(OP_STEP, 4'd0, 16'd0);
    push_shift(a + 8);
    wait_drain(50);
    send(OP_STOP, 4'd0, 16'd0);

    // Rate 2: write held off on the due cycle, lands one cycle later
    send(OP_SET_RATE, 4'd0, 16'd2);
    send(OP_RUN, 4'd0, 16'd0);
    a = last_acc;
    push_shift(a + 3);
    wait_cyc(a + 2);
    chk("holdoff_ready", cmd_ready, 1'b0);
    send(OP_WRITE, 4'd0, 16'h005A);
    chk("holdoff_acc_cycle", last_acc, a + 4);
    chk("holdoff_write", reg_out[7:0], 8'h5A);
    push_shift(a + 6);
    wait_drain(50);

    // Asynchronous reset mid-run drops an in-flight CLEAR
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_CLEAR;
    #1 rst = 1'b1;
    #1;
    chk("midrun_rst_pattern", reg_out, RST_FLAT);
    chk("midrun_rst_running", running, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 3'd0;
    rst = 1'b0;
    model_reset();
    sb_q.delete();
    @(negedge clk);
    chk("post_rst_pattern", reg_out, RST_FLAT);

    // Opcode 0: READ with readback, otherwise a NOP
    send(3'd0, 4'd7, 16'd0);
`ifdef SHIFT_SEQ_READBACK_EN
    chk("read_valid", rd_valid, 1'b1);
    chk("read_data", rd_data, 8'hFF);
    @(negedge clk);
    chk("read_valid_drop", rd_valid, 1'b0);
`else
    chk("nop_rd_valid", rd_valid, 1'b0);
    chk("nop_rd_data", rd_data, 8'h00);
    chk("nop_pattern", reg_out, RST_FLAT);
`endif

    // CLEAR while running zeroes the pattern and keeps running
    send(OP_SET_RATE, 4'd0, 16'd3);
    send(OP_RUN, 4'd0, 16'd0);
    a = last_acc;
    send(OP_CLEAR, 4'd0, 16'd0);
    chk("clear_pattern", reg_out, 128'd0);
    chk("clear_running", running, 1'b1);
    push_shift(a + 4);
    wait_drain(50);
    send(OP_STOP, 4'd0, 16'd0);

    // Rate 0: shift every cycle, commands held off the whole run
    send(OP_WRITE, 4'd0, 16'h0081);
    send(OP_WRITE, 4'd9, 16'h007E);
    send(OP_SET_RATE, 4'd0, 16'd0);
    send(OP_RUN, 4'd0, 16'd0);
    a = last_acc;
    chk("rate0_ready", cmd_ready, 1'b0);
    for (int k = 1; k <= 16; k++) push_shift(a + k);
    wait_drain(50);
    chk("rate0_elem0", reg_out[7:0], 8'h81);
    chk("rate0_elem9", reg_out[79:72], 8'h7E);
    rst = 1'b1;
    #1;
    chk("rate0_rst_running", running, 1'b0);
    chk("rate0_rst_pattern", reg_out, RST_FLAT);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    chk("sb_leftover", sb_q.size(), 0);
    chk("rd_leftover", rd_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
